// File: rtl/rv_imm_dec_stage.sv
// ============================================================================
// Module   : rv_imm_dec_stage
// Brief    : RV32/RV64 immediate decode stage with 2-entry skid buffer
//            and saturating illegal-opcode counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_imm_dec_stage #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           in_instr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_instr_o,
    output logic [DATA_WIDTH-1:0] out_imm_o,
    output logic [2:0]            out_fmt_o,
    output logic                  out_illegal_o,
    output logic [CNT_WIDTH-1:0]  ill_cnt_o
);

    localparam logic [2:0] c_FMT_R = 3'd0;
    localparam logic [2:0] c_FMT_I = 3'd1;
    localparam logic [2:0] c_FMT_S = 3'd2;
    localparam logic [2:0] c_FMT_B = 3'd3;
    localparam logic [2:0] c_FMT_U = 3'd4;
    localparam logic [2:0] c_FMT_J = 3'd5;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_in_ready;
    logic [CNT_WIDTH-1:0]    r_cnt;

    logic [31:0]             r_s0_instr;
    logic [DATA_WIDTH-1:0]   r_s0_imm;
    logic [2:0]              r_s0_fmt;
    logic                    r_s0_ill;
    logic [31:0]             r_s1_instr;
    logic [DATA_WIDTH-1:0]   r_s1_imm;
    logic [2:0]              r_s1_fmt;
    logic                    r_s1_ill;

    logic [2:0]              w_fmt;
    logic                    w_illegal;
    logic [31:0]             w_imm32;
    logic [DATA_WIDTH-1:0]   w_imm;

    logic                    w_accept;
    logic                    w_issue;
    logic                    w_load_s0;
    logic                    w_load_s1;
    logic                    w_shift;

    // Opcode classification and 32-bit immediate assembly.
    always_comb begin
        w_fmt     = c_FMT_R;
        w_illegal = 1'b0;
        w_imm32   = 32'd0;
        case (in_instr_i[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: w_fmt = c_FMT_I;
            7'b0100011:                                     w_fmt = c_FMT_S;
            7'b1100011:                                     w_fmt = c_FMT_B;
            7'b0110111, 7'b0010111:                         w_fmt = c_FMT_U;
            7'b1101111:                                     w_fmt = c_FMT_J;
            7'b0110011, 7'b0111011:                         w_fmt = c_FMT_R;
            default:                                        w_illegal = 1'b1;
        endcase
        case (w_fmt)
            c_FMT_I: w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            c_FMT_S: w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
            c_FMT_B: w_imm32 = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                                in_instr_i[30:25], in_instr_i[11:8], 1'b0};
            c_FMT_U: w_imm32 = {in_instr_i[31:12], 12'd0};
            c_FMT_J: w_imm32 = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                                in_instr_i[20], in_instr_i[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    assign w_imm = DATA_WIDTH'($signed(w_imm32));

    assign w_accept = in_valid_i & r_in_ready;
    assign w_issue  = (r_state != S_EMPTY) & out_ready_i;

    always_comb begin
        w_next    = r_state;
        w_load_s0 = 1'b0;
        w_load_s1 = 1'b0;
        w_shift   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next    = S_ONE;
                    w_load_s0 = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && !w_issue) begin
                    w_next    = S_TWO;
                    w_load_s1 = 1'b1;
                end else if (!w_accept && w_issue) begin
                    w_next    = S_EMPTY;
                end else if (w_accept && w_issue) begin
                    w_load_s0 = 1'b1;
                end
            end
            S_TWO: begin
                if (w_issue) begin
                    w_next  = S_ONE;
                    w_shift = 1'b1;
                end
            end
            default: w_next = S_EMPTY;
        endcase
        // Flush overrides every same-cycle transfer.
        if (flush_i) begin
            w_next    = S_EMPTY;
            w_load_s0 = 1'b0;
            w_load_s1 = 1'b0;
            w_shift   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
            r_s0_instr <= '0;
            r_s0_imm   <= '0;
            r_s0_fmt   <= '0;
            r_s0_ill   <= 1'b0;
            r_s1_instr <= '0;
            r_s1_imm   <= '0;
            r_s1_fmt   <= '0;
            r_s1_ill   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != S_TWO);
            if (w_load_s0) begin
                r_s0_instr <= in_instr_i;
                r_s0_imm   <= w_imm;
                r_s0_fmt   <= w_fmt;
                r_s0_ill   <= w_illegal;
            end else if (w_shift) begin
                r_s0_instr <= r_s1_instr;
                r_s0_imm   <= r_s1_imm;
                r_s0_fmt   <= r_s1_fmt;
                r_s0_ill   <= r_s1_ill;
            end
            if (w_load_s1) begin
                r_s1_instr <= in_instr_i;
                r_s1_imm   <= w_imm;
                r_s1_fmt   <= w_fmt;
                r_s1_ill   <= w_illegal;
            end
            if (w_accept && w_illegal && !flush_i && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign in_ready_o    = r_in_ready;
    assign out_valid_o   = (r_state != S_EMPTY);
    assign out_instr_o   = r_s0_instr;
    assign out_imm_o     = r_s0_imm;
    assign out_fmt_o     = r_s0_fmt;
    assign out_illegal_o = r_s0_ill;
    assign ill_cnt_o     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rv_imm_dec_stage.sv
// ============================================================================
// Module   : tb_rv_imm_dec_stage
// Brief    : Randomized self-checking bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv_imm_dec_stage;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [31:0]   in_instr_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [31:0]   out_instr_o;
    logic [DW-1:0] out_imm_o;
    logic [2:0]    out_fmt_o;
    logic          out_illegal_o;
    logic [CW-1:0] ill_cnt_o;

    always #5 clk_i = ~clk_i;

    rv_imm_dec_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_instr_i    (in_instr_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_instr_o   (out_instr_o),
        .out_imm_o     (out_imm_o),
        .out_fmt_o     (out_fmt_o),
        .out_illegal_o (out_illegal_o),
        .ill_cnt_o     (ill_cnt_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        int          fmt;
        bit          ill;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   m_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Immediates built with signed shifts on a sign-extended copy of the word.
    function automatic ent_t ref_decode(input logic [31:0] ins);
        ent_t  e;
        longint s;
        longint u;
        s = longint'($signed(ins));
        u = longint'({32'd0, ins});
        e.instr = ins;
        e.imm   = 64'd0;
        e.fmt   = 0;
        e.ill   = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67: e.fmt = 1;
            7'h23:                      e.fmt = 2;
            7'h63:                      e.fmt = 3;
            7'h37, 7'h17:               e.fmt = 4;
            7'h6F:                      e.fmt = 5;
            7'h33, 7'h3B:               e.fmt = 0;
            default:                    e.ill = 1'b1;
        endcase
        case (e.fmt)
            1: e.imm = s >>> 20;
            2: e.imm = ((s >>> 25) <<< 5) | ((u >> 7) & 31);
            3: e.imm = ((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11)
                     | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
            4: e.imm = s & ~longint'(4095);
            5: e.imm = ((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12)
                     | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
            default: e.imm = 64'd0;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ready = 1'b1;
        m_cnt   = 0;
    endtask

    // One clock: drive at negedge, compare settled outputs, then advance the model.
    task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
        bit acc;
        bit iss;
        @(negedge clk_i);
        in_valid_i  = v;
        in_instr_i  = ins;
        out_ready_i = rdy;
        flush_i     = fl;
        #1;
        check_eq("out_valid", {63'd0, out_valid_o}, {63'd0, q.size() > 0});
        check_eq("in_ready", {63'd0, in_ready_o}, {63'd0, m_ready});
        check_eq("ill_cnt", {60'd0, ill_cnt_o}, 64'(m_cnt));
        if (q.size() > 0) begin
            check_eq("head_instr", {32'd0, out_instr_o}, {32'd0, q[0].instr});
            check_eq("head_imm", out_imm_o, q[0].imm);
            check_eq("head_fmt", {61'd0, out_fmt_o}, 64'(q[0].fmt));
            check_eq("head_ill", {63'd0, out_illegal_o}, {63'd0, q[0].ill});
        end
        if (fl) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            acc = v && m_ready;
            iss = (q.size() > 0) && rdy;
            if (iss) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(ins));
                if (ref_decode(ins).ill && m_cnt < (1 << CW) - 1) m_cnt++;
            end
            m_ready = (q.size() < 2);
        end
    endtask

    task automatic settle();
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [6:0] c_OPS [10] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23,
                                         7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    initial begin
        logic [31:0] r;
        int          cnt_before;
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_instr_i  = 32'd0;
        out_ready_i = 1'b0;
        model_reset();
        #12;
        check_eq("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        check_eq("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        check_eq("rst_imm", out_imm_o, 64'd0);
        check_eq("rst_instr", {32'd0, out_instr_o}, 64'd0);
        check_eq("rst_fmt_ill_cnt", {56'd0, out_fmt_o, out_illegal_o, ill_cnt_o}, 64'd0);
        rst_n_i = 1'b1;

        // addi x1,x0,-1
        step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        settle();
        check_eq("addi_valid", {63'd0, out_valid_o}, 64'd1);
        check_eq("addi_fmt", {61'd0, out_fmt_o}, 64'd1);
        check_eq("addi_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("addi_ill", {63'd0, out_illegal_o}, 64'd0);

        // Back-to-back stream
        step(1'b1, 32'hFE112E23, 1'b1, 1'b0); settle();
        check_eq("sw_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("sw_fmt", {61'd0, out_fmt_o}, 64'd2);
        step(1'b1, 32'h00000863, 1'b1, 1'b0); settle();
        check_eq("beq_imm", out_imm_o, 64'h10);
        check_eq("beq_fmt", {61'd0, out_fmt_o}, 64'd3);
        step(1'b1, 32'hFF9FF06F, 1'b1, 1'b0); settle();
        check_eq("jal_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("jal_fmt", {61'd0, out_fmt_o}, 64'd5);
        step(1'b1, 32'h800000B7, 1'b1, 1'b0); settle();
        check_eq("lui_imm", out_imm_o, 64'hFFFF_FFFF_8000_0000);
        check_eq("lui_fmt", {61'd0, out_fmt_o}, 64'd4);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure: third word waits until space frees up
        step(1'b1, 32'h00100113, 1'b0, 1'b0);
        step(1'b1, 32'h00200193, 1'b0, 1'b0);
        settle();
        check_eq("bp_in_ready", {63'd0, in_ready_o}, 64'd0);
        step(1'b1, 32'h00300213, 1'b0, 1'b0);
        step(1'b1, 32'h00300213, 1'b0, 1'b0);
        step(1'b1, 32'h00300213, 1'b1, 1'b0);
        step(1'b1, 32'h00300213, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Illegal opcodes
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        step(1'b1, 32'h123450B7, 1'b1, 1'b0);
        settle();
        check_eq("lui2_imm", out_imm_o, 64'h1234_5000);
        check_eq("ill_cnt_two", {60'd0, ill_cnt_o}, 64'd2);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush while full, with an illegal word offered the same cycle
        cnt_before = m_cnt;
        step(1'b1, 32'h00500293, 1'b0, 1'b0);
        step(1'b1, 32'h00600313, 1'b0, 1'b0);
        step(1'b1, 32'h0000007F, 1'b0, 1'b1);
        settle();
        check_eq("flush_valid", {63'd0, out_valid_o}, 64'd0);
        check_eq("flush_ready", {63'd0, in_ready_o}, 64'd1);
        check_eq("flush_cnt", {60'd0, ill_cnt_o}, 64'(cnt_before));
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset while holding one entry
        step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        settle();
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, out_valid_o}, 64'd0);
        check_eq("arst_imm", out_imm_o, 64'd0);
        check_eq("arst_instr", {32'd0, out_instr_o}, 64'd0);
        check_eq("arst_misc", {56'd0, out_fmt_o, out_illegal_o, ill_cnt_o}, 64'd0);
        check_eq("arst_ready", {63'd0, in_ready_o}, 64'd1);
        model_reset();
        rst_n_i = 1'b1;

        // Randomized traffic; enough illegals to reach counter saturation
        for (int i = 0; i < 3000; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) != 0) r[6:0] = c_OPS[$urandom_range(0, 9)];
            step($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0);
        end
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("cnt_saturated", 64'(m_cnt), 64'((1 << CW) - 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
